// File: rtl/i2c_multi_slave_rx.sv
// Write-only I2C slave front end answering NUM_CH addresses; each full frame is
// committed to its channel register and handed off via a per-channel ready/rd handshake.
module i2c_multi_slave_rx #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned FRAME_BYTES = 6,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            scl,
   input  logic                            sda_in,
   output logic                            sda_oe,
   input  logic [NUM_CH*7-1:0]             dev_addr,
   input  logic [NUM_CH-1:0]               rd,
   output logic [NUM_CH-1:0]               ready,
   output logic [NUM_CH-1:0]               overrun,
   output logic [NUM_CH*FRAME_BYTES*8-1:0] data,
   output logic                            frame_err,
   output logic                            busy
);

   localparam int unsigned FW   = FRAME_BYTES * 8;
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned BC_W = $clog2(FRAME_BYTES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_e;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_h_q, sda_h_q;
   state_e                 state_q;
   logic [2:0]             bit_cnt_q;
   logic [BC_W-1:0]        byte_cnt_q;
   logic [6:0]             shift_q;
   logic [FW-1:0]          shadow_q;
   logic [CH_W-1:0]        ch_q;
   logic                   sda_oe_q, frame_err_q, busy_q;
   logic [NUM_CH-1:0]      ready_q, overrun_q;
   logic [NUM_CH*FW-1:0]   data_q;

   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]             byte_d;
   logic [FW-1:0]          frame_d;
   logic                   byte_done, last_byte, commit;
   logic                   match;
   logic [CH_W-1:0]        match_ch;

   // Input synchronisers plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '0;
         sda_sync_q <= '0;
         scl_h_q    <= 1'b0;
         sda_h_q    <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_h_q    <= scl_s;
         sda_h_q    <= sda_s;
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_h_q;
   assign scl_fall  = ~scl_s & scl_h_q;
   assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
   assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;

   assign byte_d    = {shift_q, sda_s};
   assign frame_d   = (shadow_q << 8) | FW'(byte_d);
   assign byte_done = scl_rise & (bit_cnt_q == 3'd7);
   assign last_byte = (byte_cnt_q == BC_W'(FRAME_BYTES - 1));
   assign commit    = (state_q == S_DATA) & byte_done & last_byte;

   // Address decode: lowest matching channel index wins.
   always_comb begin
      match    = 1'b0;
      match_ch = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (!match && (byte_d[7:1] == dev_addr[7*k +: 7])) begin
            match    = 1'b1;
            match_ch = CH_W'(k);
         end
      end
   end

   // Protocol FSM; START/STOP take priority over any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         shift_q     <= '0;
         shadow_q    <= '0;
         ch_q        <= '0;
         sda_oe_q    <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         if (start_det) begin
            state_q    <= S_ADDR;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b1;
         end else if (stop_det) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            if ((byte_cnt_q != '0) && (byte_cnt_q != BC_W'(FRAME_BYTES)))
               frame_err_q <= 1'b1;
         end else begin
            case (state_q)
               S_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (byte_done) begin
                        if (match && !byte_d[0]) begin
                           ch_q    <= match_ch;
                           state_q <= S_ADDR_ACK;
                        end else begin
                           state_q <= S_IGNORE;
                        end
                     end
                  end
               end
               // First scl fall ends bit 8 and starts ACK; the second ends the ACK bit.
               S_ADDR_ACK, S_DATA_ACK: begin
                  if (scl_fall) begin
                     if (!sda_oe_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        if ((state_q == S_DATA_ACK) && (byte_cnt_q == BC_W'(FRAME_BYTES)))
                           state_q <= S_IGNORE;
                        else
                           state_q <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= byte_d[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (byte_done) begin
                        shadow_q   <= frame_d;
                        byte_cnt_q <= byte_cnt_q + BC_W'(1);
                        state_q    <= S_DATA_ACK;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Per-channel frame registers; a commit beats a same-cycle read.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q   <= '0;
         overrun_q <= '0;
         data_q    <= '0;
      end else begin
         for (int k = 0; k < int'(NUM_CH); k++) begin
            if (commit && (ch_q == CH_W'(k))) begin
               data_q[k*FW +: FW] <= frame_d;
               ready_q[k]         <= 1'b1;
               overrun_q[k]       <= ~rd[k] & (overrun_q[k] | ready_q[k]);
            end else if (rd[k] && ready_q[k]) begin
               ready_q[k]   <= 1'b0;
               overrun_q[k] <= 1'b0;
            end
         end
      end
   end

   assign sda_oe    = sda_oe_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
   assign ready     = ready_q;
   assign overrun   = overrun_q;
   assign data      = data_q;

endmodule

// File: tb/tb_i2c_multi_slave_rx.sv
// Bench for i2c_multi_slave_rx: bit-banged I2C master, commit scoreboard, direct checks.
module tb_i2c_multi_slave_rx;

   localparam int NUM_CH = 3;
   localparam int FB     = 6;
   localparam int SYNC   = 2;
   localparam int H      = 8;
   localparam int FW     = FB * 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   scl;
   logic                   sda_m;
   wire                    sda_bus;
   logic                   sda_oe;
   logic [NUM_CH*7-1:0]    dev_addr;
   logic [NUM_CH-1:0]      rd;
   logic [NUM_CH-1:0]      ready;
   logic [NUM_CH-1:0]      overrun;
   logic [NUM_CH*FW-1:0]   data;
   logic                   frame_err;
   logic                   busy;

   // Open-drain bus: the slave's ACK overrides the master's released line.
   assign sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_multi_slave_rx #(
      .NUM_CH      (NUM_CH),
      .FRAME_BYTES (FB),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .dev_addr  (dev_addr),
      .rd        (rd),
      .ready     (ready),
      .overrun   (overrun),
      .data      (data),
      .frame_err (frame_err),
      .busy      (busy)
   );

   typedef struct {
      int          ch;
      logic [47:0] d;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         sb_e;
   int          n_checks = 0;
   int          n_errors = 0;
   int          fe_cnt   = 0;
   logic [47:0] prev [NUM_CH];
   logic [47:0] mon_s;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Commit monitor: a changed channel slice with ready high must match the queue head.
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      for (int k = 0; k < NUM_CH; k++) begin
         mon_s = data[k*FW +: FW];
         if (mon_s !== prev[k] && ready[k] === 1'b1) begin
            check($sformatf("sb_pending_ch%0d", k), 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               sb_e = sb_q.pop_front();
               check($sformatf("sb_ch%0d", k), 64'(k), 64'(sb_e.ch));
               check($sformatf("sb_data_ch%0d", k), 64'(mon_s), 64'(sb_e.d));
            end
         end
         prev[k] = mon_s;
      end
   end

   task automatic i2c_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; i2c_wait(H);
      scl   = 1'b1; i2c_wait(H);
      sda_m = 1'b0; i2c_wait(H);
      scl   = 1'b0; i2c_wait(H);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; i2c_wait(H);
      scl   = 1'b1; i2c_wait(H);
      sda_m = 1'b1; i2c_wait(H);
   endtask

   // rd_m is pulsed so that it lands in the DUT's commit cycle for this bit.
   task automatic i2c_bit(input logic b, input logic [NUM_CH-1:0] rd_m);
      sda_m = b; i2c_wait(H);
      scl   = 1'b1;
      if (rd_m != '0) begin
         i2c_wait(SYNC);
         rd = rd_m;
         i2c_wait(1);
         rd = '0;
         i2c_wait(H - SYNC - 1);
      end else begin
         i2c_wait(H);
      end
      scl = 1'b0; i2c_wait(H);
   endtask

   task automatic i2c_byte(input logic [7:0] b, input logic [NUM_CH-1:0] rd_m, output logic ack);
      for (int i = 7; i >= 0; i--) i2c_bit(b[i], (i == 0) ? rd_m : '0);
      sda_m = 1'b1; i2c_wait(H);
      scl   = 1'b1; i2c_wait(H / 2);
      ack   = sda_oe;
      i2c_wait(H / 2);
      scl   = 1'b0; i2c_wait(H);
   endtask

   task automatic frame_body(input logic [7:0] a, input logic [47:0] d,
                             input logic [NUM_CH-1:0] rd_m, input string tag);
      logic ack;
      int   n;
      n = 0;
      i2c_start();
      check({tag, "_busy_start"}, 64'(busy), 64'd1);
      i2c_byte(a, '0, ack);
      n += int'(ack);
      for (int i = 0; i < FB; i++) begin
         i2c_byte(d[47-8*i -: 8], (i == FB - 1) ? rd_m : '0, ack);
         n += int'(ack);
      end
      check({tag, "_acks"}, 64'(n), 64'd7);
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [47:0] d, input int ch,
                             input logic [NUM_CH-1:0] rd_m, input string tag);
      sb_q.push_back('{ch: ch, d: d});
      frame_body(a, d, rd_m, tag);
      i2c_stop();
      check({tag, "_busy_stop"}, 64'(busy), 64'd0);
   endtask

   initial begin
      logic ack;
      int   fe0;
      rst      = 1'b1;
      scl      = 1'b1;
      sda_m    = 1'b1;
      rd       = '0;
      dev_addr = {7'h1E, 7'h6B, 7'h19};
      for (int k = 0; k < NUM_CH; k++) prev[k] = '0;
      i2c_wait(4);
      rst = 1'b0;
      i2c_wait(4);

      check("rst_ready",   64'(ready),     64'd0);
      check("rst_overrun", 64'(overrun),   64'd0);
      check("rst_data",    64'(|data),     64'd0);
      check("rst_busy",    64'(busy),      64'd0);
      check("rst_sda_oe",  64'(sda_oe),    64'd0);
      check("rst_ferr",    64'(frame_err), 64'd0);

      // Full frame to ch0
      send_frame(8'h32, 48'h010203040506, 0, '0, "t2");
      check("t2_ready", 64'(ready), 64'b001);
      check("t2_data",  64'(data[47:0]), 64'h010203040506);

      // Reset pulse during bit 4 of the address byte
      i2c_start();
      for (int i = 7; i > 4; i--) i2c_bit(1'(8'h32 >> i), '0);
      check("t1_busy_pre", 64'(busy), 64'd1);
      sda_m = 1'b1; i2c_wait(H);
      scl   = 1'b1; i2c_wait(2);
      rst   = 1'b1; i2c_wait(1);
      rst   = 1'b0;
      check("t1_ready",   64'(ready),   64'd0);
      check("t1_overrun", 64'(overrun), 64'd0);
      check("t1_data",    64'(|data),   64'd0);
      check("t1_busy",    64'(busy),    64'd0);
      check("t1_sda_oe",  64'(sda_oe),  64'd0);
      i2c_wait(H - 3);
      scl = 1'b0; i2c_wait(H);
      fe0 = fe_cnt;
      i2c_stop();
      check("t1_no_ferr", 64'(fe_cnt - fe0), 64'd0);
      send_frame(8'h32, 48'hA1A2A3A4A5A6, 0, '0, "t1b");
      check("t1b_ready", 64'(ready), 64'b001);

      // Two ch1 frames without a read -> overrun, then read clears both flags
      send_frame(8'hD6, 48'hB1B2B3B4B5B6, 1, '0, "t3a");
      send_frame(8'hD6, 48'hC1C2C3C4C5C6, 1, '0, "t3b");
      check("t3_ready1",   64'(ready[1]),     64'd1);
      check("t3_overrun1", 64'(overrun[1]),   64'd1);
      check("t3_data1",    64'(data[95:48]),  64'hC1C2C3C4C5C6);
      rd = 3'b010; i2c_wait(1);
      rd = '0;
      check("t3_rd_ready",   64'(ready),   64'b001);
      check("t3_rd_overrun", 64'(overrun), 64'b000);

      // Non-matching address, then a read to a valid address: no ACK
      i2c_start();
      check("t4a_busy", 64'(busy), 64'd1);
      i2c_byte(8'hA0, '0, ack);
      check("t4a_nack", 64'(ack), 64'd0);
      i2c_stop();
      check("t4a_busy_stop", 64'(busy), 64'd0);
      i2c_start();
      i2c_byte(8'h33, '0, ack);
      check("t4b_nack", 64'(ack), 64'd0);
      i2c_byte(8'h55, '0, ack);
      check("t4b_nack_data", 64'(ack), 64'd0);
      i2c_stop();
      check("t4_ready", 64'(ready), 64'b001);

      // Short ch2 frame -> frame_err pulse, nothing committed
      fe0 = fe_cnt;
      i2c_start();
      i2c_byte(8'h3C, '0, ack);
      check("t5_addr_ack", 64'(ack), 64'd1);
      i2c_byte(8'h11, '0, ack);
      i2c_byte(8'h22, '0, ack);
      i2c_byte(8'h33, '0, ack);
      check("t5_ack3", 64'(ack), 64'd1);
      i2c_stop();
      check("t5_ferr_pulse", 64'(fe_cnt - fe0), 64'd1);
      check("t5_ready2",     64'(ready[2]),     64'd0);

      // Repeated START mid-frame, then a full ch2 frame and a surplus byte
      fe0 = fe_cnt;
      sb_q.push_back('{ch: 2, d: 48'hD1D2D3D4D5D6});
      i2c_start();
      i2c_byte(8'h3C, '0, ack);
      i2c_byte(8'h44, '0, ack);
      i2c_byte(8'h55, '0, ack);
      frame_body(8'h3C, 48'hD1D2D3D4D5D6, '0, "t5b");
      i2c_byte(8'hEE, '0, ack);
      check("t5b_extra_nack", 64'(ack), 64'd0);
      i2c_stop();
      check("t5b_no_ferr", 64'(fe_cnt - fe0), 64'd0);
      check("t5b_ready",   64'(ready),        64'b101);
      check("t5b_data2",   64'(data[143:96]), 64'hD1D2D3D4D5D6);

      // Read strobe in the exact commit cycle of a new ch0 frame
      check("t6_ready0_pre", 64'(ready[0]), 64'd1);
      send_frame(8'h32, 48'h5A5B5C5D5E5F, 0, 3'b001, "t6");
      check("t6_ready0",   64'(ready[0]),    64'd1);
      check("t6_overrun0", 64'(overrun[0]),  64'd0);
      check("t6_data0",    64'(data[47:0]),  64'h5A5B5C5D5E5F);

      i2c_wait(4);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
